darkriscv_dbus_resp: RTL and testbench
======================================

# darkriscv_dbus_resp

Data-bus responder for the darkriscv core: the memory-side end of the core's data port. It decodes requests (DAS/DRD/DWR/DLEN/DADDR/DATAO) addressed to a local word-organised RAM, inserts a programmable number of wait states by driving HLT, commits byte-lane writes and returns read data on DATAI. It sits between the core's data port and the SoC data RAM, one instance per core.

## Interface
- BASE_ADDR, 32'h0000_1000, byte address of RAM word 0; must be aligned to DEPTH*4
- DEPTH, 256, RAM size in 32-bit words, power of two, 4..4096
- WAIT, 1, stall cycles per accepted access, 0..15
- CLK  in  1  clock, all state on rising edge
- RES  in  1  synchronous active-high reset
- DAS  in  1  address strobe, request valid
- DRD  in  1  read request
- DWR  in  1  write request
- DLEN  in  3  access length: 3'd1 byte, 3'd2 half, 3'd4 word
- DADDR  in  32  byte address
- DATAO  in  32  write data, already lane-positioned by the core
- DATAI  out  32  read data, full word
- HLT  out  1  stall to core
- DERR  out  1  one-cycle pulse on a faulted access
- DEBUG  out  4  {state[1:0], hit, DERR}
- ESIMREQ  in  1  end-simulation request (only with DRESP_ESIM_EN)
- ESIMACK  out  1  end-simulation acknowledge (only with DRESP_ESIM_EN)

## Operation
- hit = DAS & (DRD|DWR) & DADDR in [BASE_ADDR, BASE_ADDR+DEPTH*4). Non-hit requests are ignored: no HLT, DATAI=0, no DERR.
- States: IDLE, WAITS, DONE.
- IDLE: on hit with WAIT=0, access completes in the same cycle (stay IDLE). On hit with WAIT>0, latch DADDR/DLEN/DATAO/DRD/DWR, load counter=WAIT-1, go WAITS.
- WAITS: counter decrements each cycle; at 0 go DONE. Request inputs ignored; latched values used.
- DONE: access completes, return to IDLE. A new hit is sampled next cycle, not in DONE.
- Completion: write commits at the closing clock edge; read drives DATAI = RAM[word index] combinationally during the completion cycle, 0 otherwise.
- Byte enables: DLEN=1 -> lane DADDR[1:0]; DLEN=2 -> lanes {DADDR[1],0} and {DADDR[1],1}; DLEN=4 -> all four. Unselected lanes unchanged.
- Fault (DERR pulse in completion cycle, write suppressed, DATAI=0): DLEN not in {1,2,4}; DLEN=2 with DADDR[0]=1; DLEN=4 with DADDR[1:0]!=0; DRD and DWR both high.
- RAM contents are not reset.

## Timing
- HLT = (IDLE & hit & WAIT>0) | WAITS. Asserted combinationally in the request cycle; high for exactly WAIT cycles; low in the completion cycle.
- Access latency: WAIT+1 cycles from request cycle to completion cycle.
- Back-to-back: with WAIT=0, one access per cycle; with WAIT>0, next request accepted the cycle after DONE.
- Reset values: state IDLE, HLT=0, DATAI=0, DERR=0, DEBUG=0, ESIMACK=0.
- RES mid-access: in-flight access aborted, write not committed, HLT=0 the cycle after RES.

## Configuration
- DRESP_ESIM_EN defined: ESIMREQ/ESIMACK present. ESIMACK rises the cycle after ESIMREQ is sampled high while state is IDLE (any in-flight access finishes first). It stays high while ESIMREQ is high and falls the cycle after ESIMREQ drops. While ESIMACK=1, hits are ignored: no HLT, no write, DATAI=0.
- DRESP_ESIM_EN undefined: ports absent, no behaviour change.

## Test plan
- WAIT=0: write word 0xDEADBEEF to BASE_ADDR, then read the same address -> HLT never high; DATAI=0xDEADBEEF in the read cycle.
- WAIT=3: byte write 0xAA at BASE_ADDR+1 over 0x11223344 -> HLT high for 3 cycles; write commits on the 4th edge; readback 0x1122AA44.
- WAIT=2: half write at BASE_ADDR+1 -> DERR pulse in cycle 3; RAM unchanged; DLEN=3'd3 read -> DATAI=0, DERR pulse.
- Access at BASE_ADDR+DEPTH*4 and BASE_ADDR-4 -> no HLT, DATAI=0, DERR=0.
- WAIT=4: RES asserted in 2nd stall cycle of a write of 0x12345678 -> HLT=0 next cycle; old data preserved.
- DRESP_ESIM_EN: ESIMREQ during a WAIT=2 read -> read completes normally; ESIMACK rises the cycle after DONE; subsequent write ignored.

Source files
------------

// File: rtl/darkriscv_dbus_resp.sv
// darkriscv data-bus responder: local word RAM with programmable wait states.
// Optional end-of-simulation handshake enabled by defining DRESP_ESIM_EN.
module darkriscv_dbus_resp #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 256,
  parameter int          WAIT      = 1
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        DAS,
  input  logic        DRD,
  input  logic        DWR,
  input  logic [2:0]  DLEN,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  output logic [31:0] DATAI,
  output logic        HLT,
  output logic        DERR,
`ifdef DRESP_ESIM_EN
  input  logic        ESIMREQ,
  output logic        ESIMACK,
`endif
  output logic [3:0]  DEBUG
);

  localparam int AW = $clog2(DEPTH);
  localparam logic HAS_WAIT = (WAIT > 0);
  localparam logic [3:0] WLOAD =
    HAS_WAIT ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAITS = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [2:0]    len_q, len_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;

  logic [31:0]   mem_q [DEPTH];

  logic          in_rng;
  logic          hit;
  logic          esim_blk;
  logic          done_c;
  logic          fast;
  logic          cpl;
  logic [AW+1:0] c_addr;
  logic [31:0]   c_wd;
  logic [2:0]    c_len;
  logic          c_rd;
  logic          c_wr;
  logic [3:0]    be;
  logic          bad;
  logic          wr_en;

  // Base is aligned to the RAM size, so a tag compare is the range check
  assign in_rng = (DADDR[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign hit    = DAS & (DRD | DWR) & in_rng & ~esim_blk;

  assign done_c = (state_q == DONE);
  assign fast   = (state_q == IDLE) & hit & ~HAS_WAIT;
  assign cpl    = ~RES & (done_c | fast);

  assign c_addr = done_c ? addr_q : DADDR[AW+1:0];
  assign c_wd   = done_c ? wdat_q : DATAO;
  assign c_len  = done_c ? len_q  : DLEN;
  assign c_rd   = done_c ? rd_q   : DRD;
  assign c_wr   = done_c ? wr_q   : DWR;

  always_comb begin
    be  = 4'b0000;
    bad = 1'b1;
    unique case (1'b1)
      (c_len == 3'd1): begin
        bad = 1'b0;
        be  = 4'b0001 << c_addr[1:0];
      end
      (c_len == 3'd2): begin
        bad = c_addr[0];
        be  = c_addr[1] ? 4'b1100 : 4'b0011;
      end
      (c_len == 3'd4): begin
        bad = |c_addr[1:0];
        be  = 4'b1111;
      end
      default: begin
        be  = 4'b0000;
        bad = 1'b1;
      end
    endcase
    bad = bad | (c_rd & c_wr);
  end

  assign wr_en = cpl & c_wr & ~bad;
  assign DERR  = cpl & bad;
  assign DATAI = (cpl & c_rd & ~bad)
               ? mem_q[c_addr[AW+1:2]] : 32'd0;

  assign HLT = ~RES &
    (((state_q == IDLE) & hit & HAS_WAIT) |
     (state_q == WAITS));

  assign DEBUG = {state_q, hit, DERR};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    len_d   = len_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (hit && HAS_WAIT) begin
          addr_d  = DADDR[AW+1:0];
          wdat_d  = DATAO;
          len_d   = DLEN;
          rd_d    = DRD;
          wr_d    = DWR;
          cnt_d   = WLOAD;
          // The request cycle is itself the first stall cycle
          state_d = (WLOAD == 4'd0) ? DONE : WAITS;
        end
      end
      WAITS: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdat_q  <= 32'd0;
      len_q   <= 3'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[c_addr[AW+1:2]][8*i +: 8] <= c_wd[8*i +: 8];
        end
      end
    end
  end

`ifdef DRESP_ESIM_EN
  logic ack_q, ack_d;

  // Rise only once the FSM is headed back to IDLE
  assign ack_d    = ESIMREQ & (ack_q | (state_d == IDLE));
  assign esim_blk = ack_q;
  assign ESIMACK  = ack_q;

  always_ff @(posedge CLK) begin
    if (RES) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end
`else
  assign esim_blk = 1'b0;
`endif

endmodule

// File: tb/tb_darkriscv_dbus_resp.sv
// Bench for darkriscv_dbus_resp: four instances with WAIT = 0, 2, 3, 4.
// Table vectors on the zero-wait instance, hand sequences for stalls.
module tb_darkriscv_dbus_resp;

  localparam logic [31:0] B = 32'h0000_1000;

  logic        clk;
  logic        res;
  logic        das;
  logic        rd;
  logic        wr;
  logic [2:0]  len;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        esimreq;
  int          sel;

  logic [31:0] datai [4];
  logic        hlt [4];
  logic        derr [4];
  logic [3:0]  dbg [4];
  logic        esimack [4];

  int ncmp;
  int nbad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    darkriscv_dbus_resp #(
      .BASE_ADDR(B),
      .DEPTH(256),
      .WAIT((g == 0) ? 0 : g + 1)
    ) u_dut (
      .CLK(clk),
      .RES(res),
      .DAS(das && (sel == g)),
      .DRD(rd),
      .DWR(wr),
      .DLEN(len),
      .DADDR(addr),
      .DATAO(wd),
      .DATAI(datai[g]),
      .HLT(hlt[g]),
      .DERR(derr[g]),
`ifdef DRESP_ESIM_EN
      .ESIMREQ((g == 1) ? esimreq : 1'b0),
      .ESIMACK(esimack[g]),
`endif
      .DEBUG(dbg[g])
    );
`ifndef DRESP_ESIM_EN
    assign esimack[g] = 1'b0;
`endif
  end

  typedef struct {
    logic        das;
    logic        rd;
    logic        wr;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] ed;
    logic        ee;
    logic        ehit;
  } vec_t;

  function automatic vec_t mk(
    input logic v_das, v_rd, v_wr,
    input logic [2:0] v_len,
    input logic [31:0] v_addr, v_wd, v_ed,
    input logic v_ee, v_hit);
    vec_t v;
    v.das  = v_das;
    v.rd   = v_rd;
    v.wr   = v_wr;
    v.len  = v_len;
    v.addr = v_addr;
    v.wd   = v_wd;
    v.ed   = v_ed;
    v.ee   = v_ee;
    v.ehit = v_hit;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    das  = 1'b0;
    rd   = 1'b0;
    wr   = 1'b0;
    len  = 3'd0;
    addr = 32'd0;
    wd   = 32'd0;
  endtask

  // Issue one access, scramble inputs after the request cycle,
  // count stall cycles and check the completion cycle.
  task automatic acc(input int s, input string nm,
                     input logic r, input logic w,
                     input logic [2:0] l,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] ed, input logic ee,
                     input int eh);
    int n;
    n    = 0;
    sel  = s;
    das  = 1'b1;
    rd   = r;
    wr   = w;
    len  = l;
    addr = a;
    wd   = d;
    @(negedge clk);
    while (hlt[s] && n < 20) begin
      n++;
      cyc();
      das  = 1'b0;
      rd   = 1'b0;
      wr   = 1'b0;
      len  = 3'd7;
      addr = 32'hFFFF_FFF0;
      wd   = 32'h5A5A_5A5A;
      @(negedge clk);
    end
    chk({nm, " stalls"}, 32'(n), 32'(eh));
    chk({nm, " datai"}, datai[s], ed);
    chk({nm, " derr"}, 32'(derr[s]), 32'(ee));
    cyc();
    idle_in();
  endtask

  vec_t tv [21];

  initial begin
    ncmp    = 0;
    nbad    = 0;
    sel     = 0;
    esimreq = 1'b0;
    res     = 1'b1;
    idle_in();

    tv[0]  = mk(1, 0, 1, 3'd4, B,        32'hDEADBEEF, 32'h0, 0, 1);
    tv[1]  = mk(1, 1, 0, 3'd4, B,        32'h0, 32'hDEADBEEF, 0, 1);
    tv[2]  = mk(1, 0, 1, 3'd4, B + 4,    32'h11223344, 32'h0, 0, 1);
    tv[3]  = mk(1, 0, 1, 3'd1, B + 6,    32'h00550000, 32'h0, 0, 1);
    tv[4]  = mk(1, 1, 0, 3'd4, B + 4,    32'h0, 32'h11553344, 0, 1);
    tv[5]  = mk(1, 0, 1, 3'd2, B + 6,    32'hBEEF0000, 32'h0, 0, 1);
    tv[6]  = mk(1, 1, 0, 3'd4, B + 4,    32'h0, 32'hBEEF3344, 0, 1);
    tv[7]  = mk(1, 0, 1, 3'd2, B + 5,    32'h00AABB00, 32'h0, 1, 1);
    tv[8]  = mk(1, 1, 0, 3'd4, B + 4,    32'h0, 32'hBEEF3344, 0, 1);
    tv[9]  = mk(1, 1, 0, 3'd4, B + 2,    32'h0, 32'h0, 1, 1);
    tv[10] = mk(1, 1, 0, 3'd3, B,        32'h0, 32'h0, 1, 1);
    tv[11] = mk(1, 1, 1, 3'd4, B,        32'h0, 32'h0, 1, 1);
    tv[12] = mk(1, 1, 0, 3'd4, B,        32'h0, 32'hDEADBEEF, 0, 1);
    tv[13] = mk(1, 1, 0, 3'd4, B + 1024, 32'h0, 32'h0, 0, 0);
    tv[14] = mk(1, 1, 0, 3'd4, B - 4,    32'h0, 32'h0, 0, 0);
    tv[15] = mk(0, 1, 0, 3'd4, B,        32'h0, 32'h0, 0, 0);
    tv[16] = mk(1, 0, 1, 3'd4, B + 1020, 32'hCAFEF00D, 32'h0, 0, 1);
    tv[17] = mk(1, 1, 0, 3'd4, B + 1020, 32'h0, 32'hCAFEF00D, 0, 1);
    tv[18] = mk(1, 1, 0, 3'd1, B + 3,    32'h0, 32'hDEADBEEF, 0, 1);
    tv[19] = mk(1, 0, 1, 3'd4, B + 1024, 32'hFFFFFFFF, 32'h0, 0, 0);
    tv[20] = mk(1, 1, 0, 3'd4, B,        32'h0, 32'hDEADBEEF, 0, 1);

    cyc();
    cyc();
    res = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst%0d hlt", k), 32'(hlt[k]), 32'd0);
      chk($sformatf("rst%0d datai", k), datai[k], 32'd0);
      chk($sformatf("rst%0d derr", k), 32'(derr[k]), 32'd0);
      chk($sformatf("rst%0d debug", k), 32'(dbg[k]), 32'd0);
      chk($sformatf("rst%0d esimack", k), 32'(esimack[k]), 32'd0);
    end
    cyc();

    for (int i = 0; i < 21; i++) begin
      sel  = 0;
      das  = tv[i].das;
      rd   = tv[i].rd;
      wr   = tv[i].wr;
      len  = tv[i].len;
      addr = tv[i].addr;
      wd   = tv[i].wd;
      @(negedge clk);
      chk($sformatf("v%0d datai", i), datai[0], tv[i].ed);
      chk($sformatf("v%0d hlt", i), 32'(hlt[0]), 32'd0);
      chk($sformatf("v%0d derr", i), 32'(derr[0]), 32'(tv[i].ee));
      chk($sformatf("v%0d debug", i), 32'(dbg[0]),
          32'({2'b00, tv[i].ehit, tv[i].ee}));
      cyc();
    end
    idle_in();

    acc(2, "w3 init", 0, 1, 3'd4, B, 32'h11223344,
        32'h0, 0, 3);
    acc(2, "w3 byte", 0, 1, 3'd1, B + 1, 32'h0000AA00,
        32'h0, 0, 3);
    acc(2, "w3 read", 1, 0, 3'd4, B, 32'h0,
        32'h1122AA44, 0, 3);

    acc(1, "w2 init", 0, 1, 3'd4, B + 16, 32'hA5A5A5A5,
        32'h0, 0, 2);
    acc(1, "w2 misal", 0, 1, 3'd2, B + 17, 32'h00FFFF00,
        32'h0, 1, 2);
    acc(1, "w2 read", 1, 0, 3'd4, B + 16, 32'h0,
        32'hA5A5A5A5, 0, 2);
    acc(1, "w2 len3", 1, 0, 3'd3, B + 16, 32'h0,
        32'h0, 1, 2);
    acc(1, "w2 above", 1, 0, 3'd4, B + 1024, 32'h0,
        32'h0, 0, 0);
    acc(1, "w2 below", 1, 0, 3'd4, B - 4, 32'h0,
        32'h0, 0, 0);

    acc(3, "w4 init", 0, 1, 3'd4, B + 32, 32'h0BADF00D,
        32'h0, 0, 4);
    sel  = 3;
    das  = 1'b1;
    wr   = 1'b1;
    len  = 3'd4;
    addr = B + 32;
    wd   = 32'h12345678;
    @(negedge clk);
    chk("w4 req hlt", 32'(hlt[3]), 32'd1);
    cyc();
    idle_in();
    res = 1'b1;
    @(negedge clk);
    cyc();
    res = 1'b0;
    @(negedge clk);
    chk("w4 post-res hlt", 32'(hlt[3]), 32'd0);
    chk("w4 post-res debug", 32'(dbg[3]), 32'd0);
    cyc();
    acc(3, "w4 keep", 1, 0, 3'd4, B + 32, 32'h0,
        32'h0BADF00D, 0, 4);

`ifdef DRESP_ESIM_EN
    esimreq = 1'b1;
    acc(1, "esim read", 1, 0, 3'd4, B + 16, 32'h0,
        32'hA5A5A5A5, 0, 2);
    @(negedge clk);
    chk("esim ack rise", 32'(esimack[1]), 32'd1);
    cyc();
    acc(1, "esim wr blk", 0, 1, 3'd4, B + 16, 32'hFFFFFFFF,
        32'h0, 0, 0);
    esimreq = 1'b0;
    cyc();
    @(negedge clk);
    chk("esim ack fall", 32'(esimack[1]), 32'd0);
    cyc();
    acc(1, "esim after", 1, 0, 3'd4, B + 16, 32'h0,
        32'hA5A5A5A5, 0, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
